logic_stream_unit: RTL and testbench

- Parametrised, registered successor to the single-bit two-input AND primitive: a WIDTH-bit bitwise logic unit with selectable operation.
- Adds a streaming accumulate mode that reduces a multi-beat packet to one result.
- Uses valid/ready handshakes on input and output, so it can sit between any producer and consumer in the datapath.

---
 rtl/logic_stream_unit.sv | 134 +++++++++++++
 tb/tb_logic_stream_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/logic_stream_unit.sv
// rtl/logic_stream_unit.sv - registered bitwise logic unit with pairwise and packet-accumulate modes
module logic_stream_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] beat_cnt_nxt;
  logic             ovf, ovf_nxt, ovf_inc;
  logic             overflow_nxt;
  logic [1:0]       cap_op, cap_op_nxt;
  logic             ready_en;
  logic             accept;

  // NAND reduces as AND; the inversion is applied only when the result is emitted.
  function automatic logic [WIDTH-1:0] reduce_op(input logic [1:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] z);
    case (o)
      2'b01:   reduce_op = x | z;
      2'b10:   reduce_op = x ^ z;
      default: reduce_op = x & z;
    endcase
  endfunction

  assign in_ready  = ready_en && ((state != HOLD) || out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    ovf_nxt      = ovf;
    cap_op_nxt   = cap_op;
    y_nxt        = y;
    beat_cnt_nxt = beat_cnt;
    overflow_nxt = overflow;
    res          = '0;
    cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    ovf_inc      = ovf || (cnt == CNT_MAX);
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          if (!mode) begin
            res          = reduce_op(op, a, b);
            y_nxt        = (op == 2'b11) ? ~res : res;
            beat_cnt_nxt = CNT_ONE;
            overflow_nxt = 1'b0;
            state_nxt    = HOLD;
          end else if (last) begin
            y_nxt        = (op == 2'b11) ? ~a : a;
            beat_cnt_nxt = CNT_ONE;
            overflow_nxt = 1'b0;
            state_nxt    = HOLD;
          end else begin
            acc_nxt    = a;
            cnt_nxt    = CNT_ONE;
            ovf_nxt    = 1'b0;
            cap_op_nxt = op;
            state_nxt  = ACC;
          end
        end else if (state == HOLD && out_ready) begin
          state_nxt = IDLE;
        end
      end
      ACC: begin
        if (accept) begin
          res = reduce_op(cap_op, acc, a);
          if (last) begin
            y_nxt        = (cap_op == 2'b11) ? ~res : res;
            beat_cnt_nxt = cnt_inc;
            overflow_nxt = ovf_inc;
            state_nxt    = HOLD;
          end else begin
            acc_nxt = res;
            cnt_nxt = cnt_inc;
            ovf_nxt = ovf_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      cap_op   <= 2'b00;
      y        <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      ovf      <= ovf_nxt;
      cap_op   <= cap_op_nxt;
      y        <= y_nxt;
      beat_cnt <= beat_cnt_nxt;
      overflow <= overflow_nxt;
      ready_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_stream_unit.sv
// tb/tb_logic_stream_unit.sv - directed self-checking bench for logic_stream_unit
module tb_logic_stream_unit;

  logic       clk;
  logic       rst;
  logic [1:0] op;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] beat_cnt;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_res;

  logic [1:0]  pw_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] pw_exp [4] = '{32'hC0, 32'hFC, 32'h3C, 32'h3F};

  logic_stream_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .beat_cnt(beat_cnt), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] o, input logic m, input logic [7:0] av,
                      input logic [7:0] bv, input logic l);
    op = o; mode = m; a = av; b = bv; last = l; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; op = 2'b00; mode = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    last = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_beat_cnt", 32'(beat_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // pairwise truth table, back to back
    for (int i = 0; i < 4; i++) begin
      beat(pw_op[i], 1'b0, 8'hF0, 8'hCC, 1'b1);
      chk("pw_valid", 32'(out_valid), 1);
      chk("pw_y", 32'(y), pw_exp[i]);
      chk("pw_cnt", 32'(beat_cnt), 1);
    end
    idle();
    chk("pw_drain", 32'(out_valid), 0);

    // accumulate XOR, op flip on beat 2 ignored
    beat(2'b10, 1'b1, 8'h01, 8'h00, 1'b0);
    chk("xor_in_acc", 32'(out_valid), 0);
    beat(2'b00, 1'b1, 8'h02, 8'h00, 1'b0);
    chk("xor_in_acc2", 32'(out_valid), 0);
    beat(2'b10, 1'b1, 8'h04, 8'h00, 1'b1);
    chk("xor_valid", 32'(out_valid), 1);
    chk("xor_y", 32'(y), 32'h07);
    chk("xor_cnt", 32'(beat_cnt), 3);
    chk("xor_ovf", 32'(overflow), 0);
    idle();

    // accumulate NAND
    beat(2'b11, 1'b1, 8'hFF, 8'h00, 1'b0);
    beat(2'b11, 1'b1, 8'h0F, 8'h00, 1'b1);
    chk("nand_y", 32'(y), 32'hF0);
    chk("nand_cnt", 32'(beat_cnt), 2);
    idle();

    // backpressure
    out_ready = 1'b0;
    beat(2'b01, 1'b0, 8'h12, 8'h21, 1'b0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_y0", 32'(y), 32'h33);
    op = 2'b10; mode = 1'b0; a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_y_stable", 32'(y), 32'h33);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid_held", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_follow", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_y", 32'(y), 32'hFF);
    idle();

    // streaming: 10 beats, 10 results in 11 cycles
    n_res = 0;
    for (int c = 0; c < 11; c++) begin
      if (c < 10) begin
        op = 2'b10; mode = 1'b0; a = 8'(c); b = 8'hF0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("st_valid", 32'(out_valid), (c < 10) ? 1 : 0);
      if (out_valid) begin
        chk("st_y", 32'(y), 32'(c ^ 32'hF0));
        n_res++;
      end
    end
    in_valid = 1'b0;
    chk("st_count", 32'(n_res), 10);

    // saturation
    for (int i = 1; i <= 20; i++)
      beat(2'b01, 1'b1, (i == 20) ? 8'h80 : 8'h00, 8'h00, (i == 20));
    chk("sat_y", 32'(y), 32'h80);
    chk("sat_cnt", 32'(beat_cnt), 15);
    chk("sat_ovf", 32'(overflow), 1);
    idle();
    beat(2'b01, 1'b1, 8'h01, 8'h00, 1'b0);
    beat(2'b01, 1'b1, 8'h02, 8'h00, 1'b1);
    chk("post_sat_y", 32'(y), 32'h03);
    chk("post_sat_cnt", 32'(beat_cnt), 2);
    chk("post_sat_ovf", 32'(overflow), 0);
    idle();

    // asynchronous reset mid-packet
    beat(2'b01, 1'b1, 8'h3C, 8'h00, 1'b0);
    beat(2'b01, 1'b1, 8'h00, 8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_y", 32'(y), 0);
    chk("mid_rst_cnt", 32'(beat_cnt), 0);
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready", 32'(in_ready), 1);
    beat(2'b01, 1'b1, 8'h01, 8'h00, 1'b1);
    chk("after_rst_valid", 32'(out_valid), 1);
    chk("after_rst_y", 32'(y), 32'h01);
    chk("after_rst_cnt", 32'(beat_cnt), 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
